clock_ready_gen: RTL and testbench

Parametrised successor to the team's 8284A-style clock generator. Derives osc, clk (1/CLK_DIV duty), pclk and vclk from the single FPGA clock mainClk as registered toggling signals. Adds N qualified ready channels with selectable 1- or 2-stage synchronisation, a minimum wait-state floor and a synchronised, stretched system reset output. Sits between the board clock and the CPU/bus interface.

---
 rtl/clock_ready_gen.sv | 176 +++++++++++++++++
 tb/tb_clock_ready_gen.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_ready_gen.sv
// clock_ready_gen
//   Board-clock front end for the CPU/bus interface. Derives osc, clk, pclk
//   and vclk from mainClk as registered toggling signals. It also qualifies
//   NUM_RDY ready requests into one synchronised ready, enforces a minimum
//   wait-state floor, and stretches the system reset out to the CPU.
//
//   Handshake: ready is a level, not a pulse. It can rise only on a clk
//   falling event, and only after the request has passed SYNC_STAGES clk
//   rising events. It falls on the first clk falling event that samples no
//   request.
//
// Ports
//   mainClk  in   FPGA clock; every register updates on its rising edge
//   rst_n    in   asynchronous active-low reset
//   rdy      in   [NUM_RDY] per-channel ready request (asynchronous)
//   aenN     in   [NUM_RDY] per-channel active-low enable qualifying rdy
//   osc      out  oscillator clock, period 2*OSC_HALF mainClk cycles
//   clk      out  CPU clock, high for one osc period out of CLK_DIV
//   pclk     out  peripheral clock, clk/2
//   vclk     out  video clock, period 2*VCLK_HALF mainClk cycles
//   ready    out  synchronised ready to the CPU
//   resetOut out  active-high system reset, released RST_HOLD clk falls
//                 after rst_n is released
module clock_ready_gen #(
    parameter int OSC_HALF    = 1,
    parameter int CLK_DIV     = 3,
    parameter int VCLK_HALF   = 2,
    parameter int NUM_RDY     = 2,
    parameter int SYNC_STAGES = 2,
    parameter int WAIT_MIN    = 0,
    parameter int RST_HOLD    = 4
) (
    input  logic               mainClk,
    input  logic               rst_n,
    input  logic [NUM_RDY-1:0] rdy,
    input  logic [NUM_RDY-1:0] aenN,
    output logic               osc,
    output logic               clk,
    output logic               pclk,
    output logic               vclk,
    output logic               ready,
    output logic               resetOut
);

    localparam int OSC_W  = (OSC_HALF  > 1) ? $clog2(OSC_HALF)     : 1;
    localparam int PH_W   = (CLK_DIV   > 1) ? $clog2(CLK_DIV)      : 1;
    localparam int VCLK_W = (VCLK_HALF > 1) ? $clog2(VCLK_HALF)    : 1;
    localparam int WAIT_W = (WAIT_MIN  > 0) ? $clog2(WAIT_MIN + 1) : 1;
    localparam int HOLD_W = (RST_HOLD  > 0) ? $clog2(RST_HOLD + 1) : 1;

    localparam logic [OSC_W-1:0]  OSC_LAST  = OSC_W'(OSC_HALF - 1);
    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(CLK_DIV - 1);
    localparam logic [VCLK_W-1:0] VCLK_LAST = VCLK_W'(VCLK_HALF - 1);
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_MIN);
    localparam logic [HOLD_W-1:0] HOLD_TGT  = HOLD_W'(RST_HOLD);

    logic [OSC_W-1:0]       osc_cnt_q, osc_cnt_d;
    logic                   osc_q, osc_d;
    logic [PH_W-1:0]        phase_q, phase_d;
    logic                   clk_q, clk_d;
    logic                   pclk_q, pclk_d;
    logic [VCLK_W-1:0]      vclk_cnt_q, vclk_cnt_d;
    logic                   vclk_q, vclk_d;
    logic [SYNC_STAGES-1:0] stage_q, stage_d;
    logic                   ready_q, ready_d;
    logic [WAIT_W-1:0]      wait_q, wait_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic                   reset_out_q, reset_out_d;

    logic osc_wrap, osc_rise, clk_rise, clk_fall, vclk_wrap, req;

    always_comb begin
        // Oscillator divider.
        osc_wrap  = (osc_cnt_q == OSC_LAST);
        osc_cnt_d = osc_wrap ? '0 : osc_cnt_q + 1'b1;
        osc_d     = osc_wrap ? ~osc_q : osc_q;
        osc_rise  = osc_wrap & ~osc_q;

        // CPU clock phase. It starts at the last phase, so the first osc
        // rise after reset wraps it to phase 0 and drives clk high. clk only
        // changes on an osc rise, so it stays aligned to osc.
        phase_d = phase_q;
        clk_d   = clk_q;
        if (osc_rise) begin
            phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
            clk_d   = (phase_d == '0);
        end
        clk_rise = clk_d & ~clk_q;
        clk_fall = ~clk_d & clk_q;

        pclk_d = clk_fall ? ~pclk_q : pclk_q;

        // Video clock runs from its own counter, independent of osc/clk.
        vclk_wrap  = (vclk_cnt_q == VCLK_LAST);
        vclk_cnt_d = vclk_wrap ? '0 : vclk_cnt_q + 1'b1;
        vclk_d     = vclk_wrap ? ~vclk_q : vclk_q;

        // Ready qualification and synchronisation.
        req     = |(rdy & ~aenN);
        stage_d = stage_q;
        ready_d = ready_q;
        wait_d  = wait_q;
        if (clk_rise) begin
            stage_d[0] = req;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
        if (clk_fall) begin
            if (!req) begin
                // Deassertion bypasses the synchroniser, so a request that
                // drops is never answered late by stale stage contents.
                ready_d = 1'b0;
                stage_d = '0;
            end else begin
                ready_d = stage_q[SYNC_STAGES-1] & (wait_q == '0);
            end
            // The wait floor restarts on every 1->0 transition of ready.
            // Otherwise it counts down once per clk fall.
            if (ready_q & ~ready_d) begin
                wait_d = WAIT_INIT;
            end else if (wait_q != '0) begin
                wait_d = wait_q - 1'b1;
            end
        end

        // Reset stretch. The counter freezes once resetOut has dropped, so
        // only rst_n can raise resetOut again.
        hold_d      = hold_q;
        reset_out_d = reset_out_q;
        if (clk_fall && reset_out_q) begin
            hold_d = hold_q + 1'b1;
            if (hold_d >= HOLD_TGT) begin
                reset_out_d = 1'b0;
            end
        end
    end

    always_ff @(posedge mainClk or negedge rst_n) begin
        if (!rst_n) begin
            osc_cnt_q   <= '0;
            osc_q       <= 1'b0;
            phase_q     <= PH_LAST;
            clk_q       <= 1'b0;
            pclk_q      <= 1'b0;
            vclk_cnt_q  <= '0;
            vclk_q      <= 1'b0;
            stage_q     <= '0;
            ready_q     <= 1'b0;
            wait_q      <= '0;
            hold_q      <= '0;
            reset_out_q <= 1'b1;
        end else begin
            osc_cnt_q   <= osc_cnt_d;
            osc_q       <= osc_d;
            phase_q     <= phase_d;
            clk_q       <= clk_d;
            pclk_q      <= pclk_d;
            vclk_cnt_q  <= vclk_cnt_d;
            vclk_q      <= vclk_d;
            stage_q     <= stage_d;
            ready_q     <= ready_d;
            wait_q      <= wait_d;
            hold_q      <= hold_d;
            reset_out_q <= reset_out_d;
        end
    end

    assign osc      = osc_q;
    assign clk      = clk_q;
    assign pclk     = pclk_q;
    assign vclk     = vclk_q;
    assign ready    = ready_q;
    assign resetOut = reset_out_q;

endmodule

// File: tb/tb_clock_ready_gen.sv
// tb_clock_ready_gen
//   Directed bench for clock_ready_gen. It drives three instances from shared
//   stimulus:
//     dut_a : defaults (2-stage sync, no wait floor)
//     dut_b : 1-stage sync
//     dut_c : 2-stage sync, WAIT_MIN=3
//   cyc counts mainClk rising edges since the last rst_n release. Outputs are
//   sampled on the falling edge of mainClk. With the default dividers, clk
//   rises on edges 1,7,13,... and falls on edges 3,9,15,...
module tb_clock_ready_gen;

    logic       mainClk = 1'b0;
    logic       rst_n   = 1'b1;
    logic [1:0] rdy     = 2'b00;
    logic [1:0] aenN    = 2'b11;

    logic osc_a, clk_a, pclk_a, vclk_a, ready_a, reset_out_a;
    logic osc_b, clk_b, pclk_b, vclk_b, ready_b, reset_out_b;
    logic osc_c, clk_c, pclk_c, vclk_c, ready_c, reset_out_c;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #10 mainClk = ~mainClk;

    clock_ready_gen dut_a (
        .mainClk(mainClk), .rst_n(rst_n), .rdy(rdy), .aenN(aenN),
        .osc(osc_a), .clk(clk_a), .pclk(pclk_a), .vclk(vclk_a),
        .ready(ready_a), .resetOut(reset_out_a)
    );

    clock_ready_gen #(.SYNC_STAGES(1)) dut_b (
        .mainClk(mainClk), .rst_n(rst_n), .rdy(rdy), .aenN(aenN),
        .osc(osc_b), .clk(clk_b), .pclk(pclk_b), .vclk(vclk_b),
        .ready(ready_b), .resetOut(reset_out_b)
    );

    clock_ready_gen #(.WAIT_MIN(3)) dut_c (
        .mainClk(mainClk), .rst_n(rst_n), .rdy(rdy), .aenN(aenN),
        .osc(osc_c), .clk(clk_c), .pclk(pclk_c), .vclk(vclk_c),
        .ready(ready_c), .resetOut(reset_out_c)
    );

    task automatic tick();
        @(negedge mainClk);
        cyc++;
    endtask

    task automatic goto(input int n);
        while (cyc < n) tick();
    endtask

    // Reset values on every instance, before any clock edge and with the
    // clock running.
    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({osc_a, clk_a, pclk_a, vclk_a, ready_a, reset_out_a} !== 6'b000001) begin
            bad++;
            $display("FAIL reset_async_a got=%b exp=000001",
                     {osc_a, clk_a, pclk_a, vclk_a, ready_a, reset_out_a});
        end
        repeat (3) tick();
        total++;
        if ({osc_a, clk_a, pclk_a, vclk_a, ready_a, reset_out_a} !== 6'b000001) begin
            bad++;
            $display("FAIL reset_held_a got=%b exp=000001",
                     {osc_a, clk_a, pclk_a, vclk_a, ready_a, reset_out_a});
        end
        total++;
        if ({osc_b, clk_b, pclk_b, vclk_b, ready_b, reset_out_b} !== 6'b000001) begin
            bad++;
            $display("FAIL reset_held_b got=%b exp=000001",
                     {osc_b, clk_b, pclk_b, vclk_b, ready_b, reset_out_b});
        end
        total++;
        if ({osc_c, clk_c, pclk_c, vclk_c, ready_c, reset_out_c} !== 6'b000001) begin
            bad++;
            $display("FAIL reset_held_c got=%b exp=000001",
                     {osc_c, clk_c, pclk_c, vclk_c, ready_c, reset_out_c});
        end
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    // Expected waveforms for edges k=1..24 after release:
    //   osc  = k odd
    //   clk  = k mod 6 in {1,2}
    //   pclk = parity of the clk falls seen so far, floor((k+3)/6)
    //   vclk = (k/2) odd
    //   resetOut = 1 until the 4th clk fall, which is edge 21
    task automatic test_clock_ratios();
        logic [5:0] exp_v;
        for (int k = 1; k <= 24; k++) begin
            tick();
            exp_v[5] = (k % 2) == 1;
            exp_v[4] = ((k % 6) == 1) || ((k % 6) == 2);
            exp_v[3] = (((k + 3) / 6) % 2) == 1;
            exp_v[2] = ((k / 2) % 2) == 1;
            exp_v[1] = 1'b0;
            exp_v[0] = (k < 21);
            total++;
            if ({osc_a, clk_a, pclk_a, vclk_a, ready_a, reset_out_a} !== exp_v) begin
                bad++;
                $display("FAIL clocks_k%0d got=%b exp=%b", k,
                         {osc_a, clk_a, pclk_a, vclk_a, ready_a, reset_out_a}, exp_v);
            end
        end
    endtask

    // Channel 0 request applied mid clk-low (edge 28). The first sampling
    // rise is edge 31. 1-stage sync asserts ready at fall 33; 2-stage sync
    // asserts it at fall 39.
    task automatic test_ready_sync();
        goto(28);
        rdy  = 2'b01;
        aenN = 2'b10;
        goto(32);
        total++;
        if ({ready_a, ready_b, ready_c} !== 3'b000) begin
            bad++;
            $display("FAIL sync_c32 got=%b exp=000", {ready_a, ready_b, ready_c});
        end
        goto(33);
        total++;
        if ({ready_a, ready_b, ready_c} !== 3'b010) begin
            bad++;
            $display("FAIL sync_c33 got=%b exp=010", {ready_a, ready_b, ready_c});
        end
        goto(38);
        total++;
        if ({ready_a, ready_b, ready_c} !== 3'b010) begin
            bad++;
            $display("FAIL sync_c38 got=%b exp=010", {ready_a, ready_b, ready_c});
        end
        goto(39);
        total++;
        if ({ready_a, ready_b, ready_c} !== 3'b111) begin
            bad++;
            $display("FAIL sync_c39 got=%b exp=111", {ready_a, ready_b, ready_c});
        end
    endtask

    // Both channels request, but neither is enabled. Then channel 1 is
    // enabled (edge 52), and later disabled again (edge 70). dut_c dropped
    // ready at fall 45, so its floor holds it low through fall 63.
    task automatic test_qualification();
        goto(40);
        rdy  = 2'b11;
        aenN = 2'b11;
        goto(44);
        total++;
        if ({ready_a, ready_b, ready_c} !== 3'b111) begin
            bad++;
            $display("FAIL qual_c44 got=%b exp=111", {ready_a, ready_b, ready_c});
        end
        goto(45);
        total++;
        if ({ready_a, ready_b, ready_c} !== 3'b000) begin
            bad++;
            $display("FAIL qual_c45 got=%b exp=000", {ready_a, ready_b, ready_c});
        end
        goto(52);
        total++;
        if ({ready_a, ready_b, ready_c} !== 3'b000) begin
            bad++;
            $display("FAIL qual_masked_c52 got=%b exp=000", {ready_a, ready_b, ready_c});
        end
        aenN = 2'b01;
        goto(57);
        total++;
        if ({ready_a, ready_b, ready_c} !== 3'b010) begin
            bad++;
            $display("FAIL qual_ch1_c57 got=%b exp=010", {ready_a, ready_b, ready_c});
        end
        goto(63);
        total++;
        if ({ready_a, ready_b, ready_c} !== 3'b110) begin
            bad++;
            $display("FAIL qual_ch1_c63 got=%b exp=110", {ready_a, ready_b, ready_c});
        end
        goto(69);
        total++;
        if ({ready_a, ready_b, ready_c} !== 3'b111) begin
            bad++;
            $display("FAIL qual_ch1_c69 got=%b exp=111", {ready_a, ready_b, ready_c});
        end
        goto(70);
        aenN = 2'b11;
        goto(74);
        total++;
        if ({ready_a, ready_b, ready_c} !== 3'b111) begin
            bad++;
            $display("FAIL qual_off_c74 got=%b exp=111", {ready_a, ready_b, ready_c});
        end
        goto(75);
        total++;
        if ({ready_a, ready_b, ready_c} !== 3'b000) begin
            bad++;
            $display("FAIL qual_off_c75 got=%b exp=000", {ready_a, ready_b, ready_c});
        end
    endtask

    // The request was off for one clk period (edges 70..76). dut_c holds
    // ready low for falls 81, 87 and 93 and reasserts it at fall 99.
    task automatic test_wait_floor();
        goto(76);
        aenN = 2'b01;
        goto(81);
        total++;
        if ({ready_a, ready_b, ready_c} !== 3'b010) begin
            bad++;
            $display("FAIL wait_c81 got=%b exp=010", {ready_a, ready_b, ready_c});
        end
        goto(87);
        total++;
        if ({ready_a, ready_b, ready_c} !== 3'b110) begin
            bad++;
            $display("FAIL wait_c87 got=%b exp=110", {ready_a, ready_b, ready_c});
        end
        goto(98);
        total++;
        if (ready_c !== 1'b0) begin
            bad++;
            $display("FAIL wait_c98 got=%b exp=0", ready_c);
        end
        goto(99);
        total++;
        if (ready_c !== 1'b1) begin
            bad++;
            $display("FAIL wait_c99 got=%b exp=1", ready_c);
        end
    endtask

    // The request drops just before the rising edge of mainClk that is clk
    // fall 105, then returns immediately. If the stages are cleared, dut_a
    // stays low at fall 111 and rises at 117.
    task automatic test_deassert_race();
        goto(104);
        total++;
        if ({ready_a, ready_b, ready_c} !== 3'b111) begin
            bad++;
            $display("FAIL race_c104 got=%b exp=111", {ready_a, ready_b, ready_c});
        end
        aenN = 2'b11;
        goto(105);
        total++;
        if ({ready_a, ready_b, ready_c} !== 3'b000) begin
            bad++;
            $display("FAIL race_c105 got=%b exp=000", {ready_a, ready_b, ready_c});
        end
        aenN = 2'b01;
        goto(111);
        total++;
        if ({ready_a, ready_b, ready_c} !== 3'b010) begin
            bad++;
            $display("FAIL race_c111 got=%b exp=010", {ready_a, ready_b, ready_c});
        end
        goto(117);
        total++;
        if ({ready_a, ready_b, ready_c} !== 3'b110) begin
            bad++;
            $display("FAIL race_c117 got=%b exp=110", {ready_a, ready_b, ready_c});
        end
        goto(129);
        total++;
        if ({ready_a, ready_b, ready_c} !== 3'b111) begin
            bad++;
            $display("FAIL race_c129 got=%b exp=111", {ready_a, ready_b, ready_c});
        end
    endtask

    // At edge 139 every clock and every ready is high. rst_n pulses low
    // between edges, then is released and the clocks restart phase-aligned.
    task automatic test_reset_midrun();
        goto(139);
        total++;
        if ({osc_a, clk_a, pclk_a, vclk_a, ready_a, reset_out_a} !== 6'b111110) begin
            bad++;
            $display("FAIL mid_pre_c139 got=%b exp=111110",
                     {osc_a, clk_a, pclk_a, vclk_a, ready_a, reset_out_a});
        end
        #3 rst_n = 1'b0;
        #1;
        total++;
        if ({osc_a, clk_a, pclk_a, vclk_a, ready_a, reset_out_a} !== 6'b000001) begin
            bad++;
            $display("FAIL mid_async_a got=%b exp=000001",
                     {osc_a, clk_a, pclk_a, vclk_a, ready_a, reset_out_a});
        end
        total++;
        if ({ready_b, reset_out_b, ready_c, reset_out_c} !== 4'b0101) begin
            bad++;
            $display("FAIL mid_async_bc got=%b exp=0101",
                     {ready_b, reset_out_b, ready_c, reset_out_c});
        end
        tick();
        rst_n = 1'b1;
        cyc   = 0;
        tick();
        total++;
        if ({osc_a, clk_a, pclk_a, vclk_a, ready_a, reset_out_a} !== 6'b110001) begin
            bad++;
            $display("FAIL mid_restart_c1 got=%b exp=110001",
                     {osc_a, clk_a, pclk_a, vclk_a, ready_a, reset_out_a});
        end
        goto(3);
        total++;
        if ({osc_a, clk_a, pclk_a, vclk_a, ready_a, reset_out_a} !== 6'b101101) begin
            bad++;
            $display("FAIL mid_restart_c3 got=%b exp=101101",
                     {osc_a, clk_a, pclk_a, vclk_a, ready_a, reset_out_a});
        end
        total++;
        if ({ready_a, ready_b, ready_c} !== 3'b010) begin
            bad++;
            $display("FAIL mid_ready_c3 got=%b exp=010", {ready_a, ready_b, ready_c});
        end
        goto(9);
        total++;
        if ({ready_a, ready_b, ready_c} !== 3'b111) begin
            bad++;
            $display("FAIL mid_ready_c9 got=%b exp=111", {ready_a, ready_b, ready_c});
        end
        goto(20);
        total++;
        if ({reset_out_a, reset_out_b, reset_out_c} !== 3'b111) begin
            bad++;
            $display("FAIL mid_rstout_c20 got=%b exp=111",
                     {reset_out_a, reset_out_b, reset_out_c});
        end
        goto(21);
        total++;
        if ({reset_out_a, reset_out_b, reset_out_c} !== 3'b000) begin
            bad++;
            $display("FAIL mid_rstout_c21 got=%b exp=000",
                     {reset_out_a, reset_out_b, reset_out_c});
        end
    endtask

    initial begin
        test_reset();
        test_clock_ratios();
        test_ready_sync();
        test_qualification();
        test_wait_floor();
        test_deassert_race();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
